data_sram_resp: RTL

- Memory-side responder for the core's data SRAM port. It accepts en/wen/addr/wdata requests from the core and returns data_sram_rdata one cycle later.
- Decodes each request to one of two targets: a word-addressed on-chip RAM, or a small configuration-register space (LED, number display, switch input, free-running timer).
- Sits in the SoC top level, directly opposite the core's data_sram_* outputs.

---
 rtl/data_sram_resp_if.sv | 24 ++
 rtl/data_sram_resp.sv | 135 +++++++++++++
 2 files changed

// File: rtl/data_sram_resp_if.sv
// Data SRAM port bundle between the core (master) and the memory-side responder (slave).
interface data_sram_resp_if;
    logic        data_sram_en;
    logic [3:0]  data_sram_wen;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic [31:0] data_sram_rdata;

    modport master (
        output data_sram_en,
        output data_sram_wen,
        output data_sram_addr,
        output data_sram_wdata,
        input  data_sram_rdata
    );

    modport slave (
        input  data_sram_en,
        input  data_sram_wen,
        input  data_sram_addr,
        input  data_sram_wdata,
        output data_sram_rdata
    );
endinterface

// File: rtl/data_sram_resp.sv
// Memory-side responder for the core data SRAM port: byte-writable word RAM plus a small
// config space (LED, number display, switches, free-running timer). Read data lags one cycle.
module data_sram_resp #(
    parameter int          RAM_AW  = 14,
    parameter logic [15:0] CONF_HI = 16'hBFAF
) (
    input  logic                    clk,
    input  logic                    rst,
    data_sram_resp_if.slave         bus,
    input  logic [7:0]              switch,
    output logic [15:0]             led,
    output logic [31:0]             num_data
);

    localparam logic [15:0] OFF_LED   = 16'hF000;
    localparam logic [15:0] OFF_NUM   = 16'hF010;
    localparam logic [15:0] OFF_SW    = 16'hF020;
    localparam logic [15:0] OFF_TIMER = 16'hE000;
    localparam logic [15:0] OFF_SIMU  = 16'hFFF4;

    function automatic logic [31:0] byte_merge(input logic [31:0] old_w,
                                               input logic [31:0] new_w,
                                               input logic [3:0]  be);
        logic [31:0] res;
        res = old_w;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                res[8*i +: 8] = new_w[8*i +: 8];
            end else begin
                res[8*i +: 8] = old_w[8*i +: 8];
            end
        end
        return res;
    endfunction

    logic [31:0]       mem [2**RAM_AW];

    logic [31:0]       rdata_q, rdata_d;
    logic [15:0]       led_q, led_d;
    logic [31:0]       num_q, num_d;
    logic [31:0]       timer_q, timer_d;

    logic              conf_s;
    logic [15:0]       off_s;
    logic [RAM_AW-1:0] ram_idx_s;
    logic              rd_s;
    logic              wr_s;
    logic              ram_we_s;
    logic [31:0]       ram_word_s;
    logic [31:0]       timer_inc_s;
    logic [31:0]       led_wide_s;

    // Request decode, read mux and next-state of all config registers.
    always_comb begin
        conf_s      = (bus.data_sram_addr[31:16] == CONF_HI);
        off_s       = bus.data_sram_addr[15:0];
        ram_idx_s   = bus.data_sram_addr[RAM_AW+1:2];
        rd_s        = bus.data_sram_en && (bus.data_sram_wen == 4'b0000);
        wr_s        = bus.data_sram_en && (bus.data_sram_wen != 4'b0000);
        ram_word_s  = mem[ram_idx_s];
        timer_inc_s = timer_q + 32'd1;
        led_wide_s  = byte_merge({16'h0000, led_q}, bus.data_sram_wdata,
                                 {2'b00, bus.data_sram_wen[1:0]});

        rdata_d  = rdata_q;
        led_d    = led_q;
        num_d    = num_q;
        timer_d  = timer_inc_s;
        ram_we_s = 1'b0;

        if (rd_s) begin
            if (conf_s) begin
                case (off_s)
                    OFF_LED:   rdata_d = {16'h0000, led_q};
                    OFF_NUM:   rdata_d = num_q;
                    OFF_SW:    rdata_d = {24'h000000, switch};
                    OFF_TIMER: rdata_d = timer_q;
                    OFF_SIMU:  rdata_d = 32'hFFFF_FFFF;
                    default:   rdata_d = 32'h0000_0000;
                endcase
            end else begin
                rdata_d = ram_word_s;
            end
        end else begin
            rdata_d = rdata_q;
        end

        // Timer writes overlay the already-incremented value so unwritten bytes keep counting.
        if (wr_s) begin
            if (conf_s) begin
                case (off_s)
                    OFF_LED:   led_d   = led_wide_s[15:0];
                    OFF_NUM:   num_d   = byte_merge(num_q, bus.data_sram_wdata, bus.data_sram_wen);
                    OFF_TIMER: timer_d = byte_merge(timer_inc_s, bus.data_sram_wdata, bus.data_sram_wen);
                    default:   ram_we_s = 1'b0;
                endcase
            end else begin
                ram_we_s = 1'b1;
            end
        end else begin
            ram_we_s = 1'b0;
        end
    end

    // Register state; reset flushes any in-flight request.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rdata_q <= 32'h0000_0000;
            led_q   <= 16'h0000;
            num_q   <= 32'h0000_0000;
            timer_q <= 32'h0000_0000;
        end else begin
            rdata_q <= rdata_d;
            led_q   <= led_d;
            num_q   <= num_d;
            timer_q <= timer_d;
        end
    end

    // Byte-enabled RAM write port; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (rst && ram_we_s) begin
            for (int i = 0; i < 4; i++) begin
                if (bus.data_sram_wen[i]) begin
                    mem[ram_idx_s][8*i +: 8] <= bus.data_sram_wdata[8*i +: 8];
                end
            end
        end
    end

    assign bus.data_sram_rdata = rdata_q;
    assign led                 = led_q;
    assign num_data            = num_q;

endmodule
